prim_bus_arbiter: RTL and testbench
===================================

Name: prim_bus_arbiter

Overview:
Two-master, one-slave arbiter for the 16-bit Prim memory bus (addr/dat/bs/we/cs/ack). Master 0 is the Prim core; master 1 is a secondary requester, such as a debug loader or DMA. One transaction is granted per arbitration, with round-robin fairness and a watchdog timeout that terminates hung slave accesses with an error ack.

Parameters:
TIMEOUT, 64, cycles a granted access waits for i_s_ack before forced termination; 0 disables the watchdog
TW, 8, width of the timeout counter; must satisfy TIMEOUT < 2**TW

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_m0_addr  in  16  master 0 address
i_m0_dat  in  16  master 0 write data
i_m0_bs  in  2  master 0 byte select
i_m0_we  in  1  master 0 write enable
i_m0_cs  in  1  master 0 request
o_m0_dat  out  16  master 0 read data
o_m0_ack  out  1  master 0 transfer complete
o_m0_err  out  1  master 0 timeout, valid with o_m0_ack
i_m1_addr, i_m1_dat, i_m1_bs, i_m1_we, i_m1_cs, o_m1_dat, o_m1_ack, o_m1_err: as for master 0
o_s_addr  out  16  slave address
o_s_dat  out  16  slave write data
o_s_bs  out  2  slave byte select
o_s_we  out  1  slave write enable
o_s_cs  out  1  slave select
i_s_dat  in  16  slave read data
i_s_ack  in  1  slave ack
o_grant  out  2  one-hot current owner; 00 when idle

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_reset.
- State after reset: IDLE, last_owner=1 (master 0 wins the first tie), timeout counter=0.
- Outputs after reset: all o_* are 0.
- States: IDLE, OWN0, OWN1.
- IDLE, arbitration:
  - Only one cs high: that master is granted at the next edge.
  - Both cs high: the master that is not last_owner is granted.
  - Arbitration latency: 1 cycle from cs high to o_s_cs high.
- OWNx, slave-side muxing:
  - o_s_addr, o_s_dat, o_s_bs and o_s_we combinationally mirror master x.
  - o_s_cs = i_mx_cs.
  - The non-owner's request is ignored, and its ack/err are held 0.
- IDLE slave outputs: all slave outputs are 0.
- OWNx, read data and ack routing:
  - o_mx_dat = i_s_dat.
  - o_mx_ack = i_s_ack, combinational, so there is no added latency on completion.
  - o_my_dat = 0 for the non-owner y.
- OWNx, completion: i_s_ack high leads to IDLE at the next edge and sets last_owner=x.
  - A master holding cs after its ack re-enters arbitration and loses any tie to the other master.
- OWNx, abort: if i_mx_cs drops before ack, go to IDLE with no ack. last_owner is still updated.
- Watchdog:
  - The counter clears on entry to OWNx and increments each cycle in OWNx without ack.
  - When the counter reaches TIMEOUT-1 with i_s_ack low, the controller emits o_mx_ack=1, o_mx_err=1 and o_mx_dat=16'hFFFF in that cycle.
  - o_s_cs is forced 0 in that cycle, and the state returns to IDLE.
  - If i_s_ack and timeout coincide, the slave ack wins and err=0.
- Stray ack: i_s_ack while in IDLE is ignored.
- Reset mid-transaction: the access is abandoned. At the next edge the state is IDLE, all slave outputs are 0 and no ack is issued.
- Throughput: a back-to-back single master gets one access per 2 cycles minimum (ack cycle + arbitration cycle).

Decomposition:
- Shared package prim_bus_pkg holds:
  - state encodings ST_IDLE/ST_OWN0/ST_OWN1;
  - bus-width constants (AW=16, DW=16, BSW=2);
  - the error read value 16'hFFFF.
- One sub-module, prim_bus_watchdog: TW-bit counter with clear, enable and expire outputs. All other logic stays in prim_bus_arbiter.

Test Plan:
- Single master: m0 reads 0x1234 and the slave acks 3 cycles after cs.
  - o_grant=01 one cycle after cs.
  - o_s_addr=0x1234 and o_s_we=0.
  - o_m0_ack pulses with o_m0_dat=i_s_dat=0xBEEF.
  - o_m1_ack stays 0.
- Tie after reset: m0 and m1 both assert cs in the same cycle.
  - m0 is granted first.
  - After m0's ack and with both still requesting, m1 is granted; m0 and m1 then alternate for 4 transactions.
- Byte write: m1 writes 0x00AB with bs=01 to 0x8001.
  - Slave sees addr 0x8001, dat 0x00AB, bs 01, we 1.
  - Ack is routed to m1 only.
- Timeout with TIMEOUT=64: m0 is granted and the slave never acks.
  - Exactly 64 cycles after grant, o_m0_ack=1, o_m0_err=1, o_m0_dat=0xFFFF and o_s_cs=0.
  - Next cycle the state is IDLE.
- Ack at the timeout cycle: i_s_ack arrives in the same cycle as expiry. Response is err=0 and data from the slave.
- Disturbances:
  - i_reset asserted mid-access leaves o_grant=00, all slave outputs 0, and no ack.
  - m1 dropping cs before ack returns the state to IDLE with no ack, and m0 is granted next.

Source files
------------

// File: rtl/prim_bus_pkg.sv
// prim_bus_pkg: shared state encodings and bus constants for the Prim bus arbiter
package prim_bus_pkg;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int BSW = 2;
  localparam logic [DW-1:0] ERR_DAT = 16'hFFFF;
  // one-hot owner encoding doubles as the grant vector
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_e;
endpackage

// File: rtl/prim_bus_watchdog.sv
// prim_bus_watchdog: access-age counter that flags the last allowed cycle of an ownership
module prim_bus_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int TW = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  logic [TW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign expire = (TIMEOUT > 0) && (cnt_q == LAST);
endmodule

// File: rtl/prim_bus_arbiter.sv
// prim_bus_arbiter: two-master round-robin arbiter for the Prim bus with a timeout watchdog
module prim_bus_arbiter
  import prim_bus_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TW = 8
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [AW-1:0]  i_m0_addr,
  input  logic [DW-1:0]  i_m0_dat,
  input  logic [BSW-1:0] i_m0_bs,
  input  logic           i_m0_we,
  input  logic           i_m0_cs,
  output logic [DW-1:0]  o_m0_dat,
  output logic           o_m0_ack,
  output logic           o_m0_err,
  input  logic [AW-1:0]  i_m1_addr,
  input  logic [DW-1:0]  i_m1_dat,
  input  logic [BSW-1:0] i_m1_bs,
  input  logic           i_m1_we,
  input  logic           i_m1_cs,
  output logic [DW-1:0]  o_m1_dat,
  output logic           o_m1_ack,
  output logic           o_m1_err,
  output logic [AW-1:0]  o_s_addr,
  output logic [DW-1:0]  o_s_dat,
  output logic [BSW-1:0] o_s_bs,
  output logic           o_s_we,
  output logic           o_s_cs,
  input  logic [DW-1:0]  i_s_dat,
  input  logic           i_s_ack,
  output logic [1:0]     o_grant
);
  state_e state_q, state_d;
  logic last_q, last_d;
  logic own0, own1, own, cs, expire, tout, done;
  assign own0 = state_q == ST_OWN0;
  assign own1 = state_q == ST_OWN1;
  assign own = own0 | own1;
  assign cs = own1 ? i_m1_cs : i_m0_cs;
  // slave ack beats a coinciding expiry
  assign tout = own & cs & expire & ~i_s_ack;
  assign done = own & (i_s_ack | ~cs | tout);
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    if (state_q == ST_IDLE)
      state_d = (i_m0_cs & (~i_m1_cs | last_q)) ? ST_OWN0 : i_m1_cs ? ST_OWN1 : ST_IDLE;
    else if (done) begin
      state_d = ST_IDLE;
      last_d = own1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
    end
  end
  prim_bus_watchdog #(.TIMEOUT(TIMEOUT), .TW(TW)) u_wdog (
    .clk(i_clk),
    .rst(i_reset),
    .clr(~own),
    .en(own & ~i_s_ack),
    .expire(expire)
  );
  assign o_grant = state_q;
  assign o_s_addr = own ? (own1 ? i_m1_addr : i_m0_addr) : '0;
  assign o_s_dat = own ? (own1 ? i_m1_dat : i_m0_dat) : '0;
  assign o_s_bs = own ? (own1 ? i_m1_bs : i_m0_bs) : '0;
  assign o_s_we = own & (own1 ? i_m1_we : i_m0_we);
  assign o_s_cs = own & cs & ~tout;
  assign o_m0_ack = own0 & (i_s_ack | tout);
  assign o_m0_err = own0 & tout;
  assign o_m0_dat = own0 ? (tout ? ERR_DAT : i_s_dat) : '0;
  assign o_m1_ack = own1 & (i_s_ack | tout);
  assign o_m1_err = own1 & tout;
  assign o_m1_dat = own1 ? (tout ? ERR_DAT : i_s_dat) : '0;
endmodule

// File: tb/tb_prim_bus_arbiter.sv
// tb_prim_bus_arbiter: directed scenarios plus a randomized run against a transaction-level model
module tb_prim_bus_arbiter;
  localparam int TIMEOUT = 64;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] addr[2], wdat[2];
  logic [1:0] bs[2];
  logic we[2], cs[2];
  logic [15:0] s_dat;
  logic s_ack;
  logic [15:0] m0_rd, m1_rd, s_addr, s_wd;
  logic m0_ack, m0_err, m1_ack, m1_err, s_we, s_cs;
  logic [1:0] s_bs, grant;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  prim_bus_arbiter #(.TIMEOUT(TIMEOUT), .TW(8)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_addr(addr[0]), .i_m0_dat(wdat[0]), .i_m0_bs(bs[0]), .i_m0_we(we[0]), .i_m0_cs(cs[0]),
    .o_m0_dat(m0_rd), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
    .i_m1_addr(addr[1]), .i_m1_dat(wdat[1]), .i_m1_bs(bs[1]), .i_m1_we(we[1]), .i_m1_cs(cs[1]),
    .o_m1_dat(m1_rd), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
    .o_s_addr(s_addr), .o_s_dat(s_wd), .o_s_bs(s_bs), .o_s_we(s_we), .o_s_cs(s_cs),
    .i_s_dat(s_dat), .i_s_ack(s_ack), .o_grant(grant)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs();
    for (int m = 0; m < 2; m++) begin
      addr[m] = '0; wdat[m] = '0; bs[m] = '0; we[m] = 1'b0; cs[m] = 1'b0;
    end
    s_dat = '0;
    s_ack = 1'b0;
  endtask
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    cs[0] = 1'b1; cs[1] = 1'b1; addr[0] = 16'h5555; s_ack = 1'b1; s_dat = 16'h1111;
    tick();
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++;
    if ({s_cs, s_we, s_bs, s_addr, s_wd} !== '0) begin
      errors++; $display("FAIL reset_slave: got cs=%b addr=%h dat=%h expected all 0", s_cs, s_addr, s_wd);
    end
    checks++;
    if ({m0_ack, m0_err, m0_rd, m1_ack, m1_err, m1_rd} !== '0) begin
      errors++; $display("FAIL reset_master: got ack0=%b ack1=%b dat0=%h expected all 0", m0_ack, m1_ack, m0_rd);
    end
    do_reset();
  endtask
  task automatic test_single();
    do_reset();
    cs[0] = 1'b1; addr[0] = 16'h1234; we[0] = 1'b0;
    #1;
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL single_latency: got grant %b expected 00", grant); end
    tick();
    checks++;
    if (grant !== 2'b01 || s_addr !== 16'h1234 || s_we !== 1'b0 || s_cs !== 1'b1) begin
      errors++; $display("FAIL single_grant: got grant=%b addr=%h we=%b cs=%b expected 01/1234/0/1", grant, s_addr, s_we, s_cs);
    end
    tick();
    checks++;
    if (m0_ack !== 1'b0) begin errors++; $display("FAIL single_early_ack: got %b expected 0", m0_ack); end
    tick();
    s_ack = 1'b1; s_dat = 16'hBEEF;
    #1;
    checks++;
    if (m0_ack !== 1'b1 || m0_dat_ok(m0_rd) !== 1'b1 || m1_ack !== 1'b0 || m0_err !== 1'b0) begin
      errors++; $display("FAIL single_ack: got ack0=%b dat0=%h ack1=%b err0=%b expected 1/beef/0/0", m0_ack, m0_rd, m1_ack, m0_err);
    end
    tick();
    cs[0] = 1'b0; s_ack = 1'b0;
    #1;
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL single_release: got grant %b expected 00", grant); end
  endtask
  function automatic logic m0_dat_ok(input logic [15:0] d);
    return d == 16'hBEEF;
  endfunction
  task automatic test_tie();
    logic [1:0] exp_g;
    do_reset();
    cs[0] = 1'b1; cs[1] = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (grant !== exp_g) begin errors++; $display("FAIL tie_grant_%0d: got %b expected %b", k, grant, exp_g); end
      s_ack = 1'b1; s_dat = 16'(k);
      #1;
      checks++;
      if ({m1_ack, m0_ack} !== exp_g) begin
        errors++; $display("FAIL tie_ack_%0d: got {ack1,ack0}=%b%b expected %b", k, m1_ack, m0_ack, exp_g);
      end
      tick();
      s_ack = 1'b0;
      #1;
      checks++;
      if (grant !== 2'b00) begin errors++; $display("FAIL tie_gap_%0d: got %b expected 00", k, grant); end
      tick();
    end
    clear_inputs();
    tick();
  endtask
  task automatic test_write();
    do_reset();
    cs[1] = 1'b1; addr[1] = 16'h8001; wdat[1] = 16'h00AB; bs[1] = 2'b01; we[1] = 1'b1;
    tick();
    checks++;
    if (grant !== 2'b10 || s_addr !== 16'h8001 || s_wd !== 16'h00AB || s_bs !== 2'b01 || s_we !== 1'b1) begin
      errors++; $display("FAIL write_slave: got g=%b addr=%h dat=%h bs=%b we=%b expected 10/8001/00ab/01/1", grant, s_addr, s_wd, s_bs, s_we);
    end
    s_ack = 1'b1;
    #1;
    checks++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
      errors++; $display("FAIL write_ack: got ack1=%b ack0=%b expected 1/0", m1_ack, m0_ack);
    end
    tick();
    clear_inputs();
    tick();
  endtask
  task automatic test_timeout();
    int n;
    do_reset();
    cs[0] = 1'b1;
    tick();
    n = 1;
    while (m0_ack !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != 64) begin errors++; $display("FAIL timeout_cycles: got %0d expected 64", n); end
    checks++;
    if (m0_ack !== 1'b1 || m0_err !== 1'b1 || m0_rd !== 16'hFFFF || s_cs !== 1'b0 || m1_ack !== 1'b0) begin
      errors++; $display("FAIL timeout_resp: got ack=%b err=%b dat=%h scs=%b ack1=%b expected 1/1/ffff/0/0", m0_ack, m0_err, m0_rd, s_cs, m1_ack);
    end
    tick();
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL timeout_idle: got %b expected 00", grant); end
    clear_inputs();
    tick();
  endtask
  task automatic test_ack_at_timeout();
    do_reset();
    cs[0] = 1'b1;
    tick();
    repeat (63) tick();
    s_ack = 1'b1; s_dat = 16'h5A5A;
    #1;
    checks++;
    if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_rd !== 16'h5A5A) begin
      errors++; $display("FAIL ack_at_timeout: got ack=%b err=%b dat=%h expected 1/0/5a5a", m0_ack, m0_err, m0_rd);
    end
    tick();
    clear_inputs();
    tick();
  endtask
  task automatic test_reset_mid();
    do_reset();
    cs[1] = 1'b1; addr[1] = 16'h0F0F; we[1] = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    s_ack = 1'b1;
    #1;
    checks++;
    if (grant !== 2'b00 || {s_cs, s_we, s_bs, s_addr, s_wd} !== '0 || m1_ack !== 1'b0 || m0_ack !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got g=%b scs=%b addr=%h ack1=%b expected 00/0/0000/0", grant, s_cs, s_addr, m1_ack);
    end
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask
  task automatic test_abort();
    do_reset();
    cs[1] = 1'b1;
    tick();
    tick();
    cs[1] = 1'b0; cs[0] = 1'b1;
    #1;
    checks++;
    if (m1_ack !== 1'b0 || grant !== 2'b10) begin
      errors++; $display("FAIL abort_noack: got ack1=%b g=%b expected 0/10", m1_ack, grant);
    end
    tick();
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL abort_idle: got %b expected 00", grant); end
    tick();
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL abort_next: got %b expected 01", grant); end
    clear_inputs();
    tick();
  endtask
  task automatic test_stray_ack();
    do_reset();
    s_ack = 1'b1; s_dat = 16'h7777;
    #1;
    checks++;
    if ({m0_ack, m1_ack, m0_rd, m1_rd, s_cs} !== '0) begin
      errors++; $display("FAIL stray_ack: got ack0=%b ack1=%b scs=%b expected 0", m0_ack, m1_ack, s_cs);
    end
    tick();
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL stray_state: got %b expected 00", grant); end
    clear_inputs();
  endtask
  task automatic test_random();
    int own, last, age;
    logic to, ack;
    logic [1:0] e_g;
    logic [15:0] rd;
    logic [73:0] exp_v, act_v;
    do_reset();
    own = -1; last = 1; age = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int m = 0; m < 2; m++) begin
        cs[m] = ($urandom_range(0, 3) != 0);
        addr[m] = 16'($urandom); wdat[m] = 16'($urandom);
        bs[m] = 2'($urandom); we[m] = 1'($urandom);
      end
      s_ack = ($urandom_range(0, 7) == 0);
      s_dat = 16'($urandom);
      #1;
      to = 1'b0;
      exp_v = '0;
      if (own >= 0) begin
        to = (TIMEOUT != 0) && (age == TIMEOUT - 1) && cs[own] && !s_ack;
        ack = s_ack || to;
        rd = to ? 16'hFFFF : s_dat;
        e_g = (own == 0) ? 2'b01 : 2'b10;
        exp_v = {e_g, cs[own] && !to, we[own], bs[own], addr[own], wdat[own],
                 (own == 0) && ack, (own == 0) && to, (own == 0) ? rd : 16'h0,
                 (own == 1) && ack, (own == 1) && to, (own == 1) ? rd : 16'h0};
      end
      act_v = {grant, s_cs, s_we, s_bs, s_addr, s_wd, m0_ack, m0_err, m0_rd, m1_ack, m1_err, m1_rd};
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL random_cycle_%0d: got %h expected %h", i, act_v, exp_v);
      end
      tick();
      if (rst) begin
        own = -1; last = 1; age = 0;
      end else if (own < 0) begin
        if (cs[0] && cs[1]) own = 1 - last;
        else if (cs[0]) own = 0;
        else if (cs[1]) own = 1;
        age = 0;
      end else if (s_ack || !cs[own] || to) begin
        last = own;
        own = -1;
      end else age++;
    end
    rst = 1'b0;
    clear_inputs();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit");
  end
  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_single();
    test_tie();
    test_write();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    test_abort();
    test_stray_ack();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
